kmeans_update_ctrl: RTL and testbench

Centroid-update sequencer for the k-means engine. After a grouping pass, it walks the four clusters in order and reads each cluster's coordinate accumulators and member count. It computes the new centroid with one shared multi-cycle restoring divider, writes the result back to the centroid register file, and reports whether every centroid stayed unchanged. It replaces per-cluster combinational dividers with a single time-shared divider, and sits between the accumulate stage and the convergence check in the top-level FSM.

---
 rtl/kmeans_update_ctrl.sv | 164 ++++++++++++++++
 tb/tb_kmeans_update_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/kmeans_update_ctrl.sv
// Centroid-update sequencer: walks the clusters, averages each one's accumulators
// with a single shared restoring divider, writes the new centroid and reports convergence.
module kmeans_update_ctrl #(
   parameter int CLUSTER_SIZE = 4,
   parameter int ACC_W        = 20,
   parameter int CNT_W        = 12,
   parameter int COORD_W      = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   output logic [1:0]           acc_sel,
   input  logic [ACC_W-1:0]     acc_x,
   input  logic [ACC_W-1:0]     acc_y,
   input  logic [CNT_W-1:0]     acc_num,
   input  logic [2*COORD_W-1:0] cent_rd,
   output logic                 cent_we,
   output logic [1:0]           cent_idx,
   output logic [2*COORD_W-1:0] cent_wdata,
   output logic                 busy,
   output logic                 done,
   output logic                 converged
);

   localparam int BIT_W = $clog2(ACC_W);
   localparam logic [1:0] LAST_K = 2'(CLUSTER_SIZE - 1);

   typedef enum logic [2:0] {IDLE, LOAD, DIV_X, DIV_Y, WRITE, FIN} state_t;

   state_t               state, state_nx;
   logic [1:0]           k;
   logic [BIT_W-1:0]     bit_cnt;
   logic [CNT_W-1:0]     num_r;
   logic [ACC_W-1:0]     ay_r;
   logic [2*COORD_W-1:0] cent_old;
   logic [COORD_W-1:0]   qx_r;
   logic                 conv_acc;
   logic [CNT_W:0]       div_rem;
   logic [ACC_W-1:0]     div_quo;

   logic [CNT_W:0]       rem_sh, rem_nx;
   logic [ACC_W-1:0]     quo_nx;
   logic                 rem_ge, last_bit, last_k, empty, conv_clear;

   function automatic logic [COORD_W-1:0] sat_coord(input logic [ACC_W-1:0] q);
      if (|q[ACC_W-1:COORD_W]) return '1;
      return q[COORD_W-1:0];
   endfunction

   assign acc_sel = k;

   // One restoring-division step; the dividend shifts out of div_quo as quotient bits shift in.
   // The remainder's top bit is always clear after a step, folding it in keeps the compare safe.
   always_comb begin
      rem_sh     = {div_rem[CNT_W-1:0], div_quo[ACC_W-1]};
      rem_ge     = div_rem[CNT_W] | (rem_sh >= {1'b0, num_r});
      rem_nx     = rem_ge ? (rem_sh - {1'b0, num_r}) : rem_sh;
      quo_nx     = {div_quo[ACC_W-2:0], rem_ge};
      last_bit   = (bit_cnt == BIT_W'(ACC_W - 1));
      last_k     = (k == LAST_K);
      empty      = (acc_num == '0);
      conv_clear = (state == WRITE) && (cent_wdata != cent_old);
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = LOAD;
         LOAD:    if (!empty)    state_nx = DIV_X;
                  else if (last_k) state_nx = FIN;
                  else           state_nx = LOAD;
         DIV_X:   if (last_bit) state_nx = DIV_Y;
         DIV_Y:   if (last_bit) state_nx = WRITE;
         WRITE:   state_nx = last_k ? FIN : LOAD;
         FIN:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k        <= '0;
         bit_cnt  <= '0;
         num_r    <= '0;
         ay_r     <= '0;
         cent_old <= '0;
         qx_r     <= '0;
         conv_acc <= 1'b0;
         div_rem  <= '0;
         div_quo  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  k        <= '0;
                  conv_acc <= 1'b1;
               end
            end
            LOAD: begin
               num_r    <= acc_num;
               ay_r     <= acc_y;
               cent_old <= cent_rd;
               div_quo  <= acc_x;
               div_rem  <= '0;
               bit_cnt  <= '0;
               if (empty) k <= k + 2'd1;
            end
            DIV_X: begin
               if (last_bit) begin
                  qx_r    <= sat_coord(quo_nx);
                  div_quo <= ay_r;
                  div_rem <= '0;
                  bit_cnt <= '0;
               end else begin
                  div_quo <= quo_nx;
                  div_rem <= rem_nx;
                  bit_cnt <= bit_cnt + BIT_W'(1);
               end
            end
            DIV_Y: begin
               div_quo <= quo_nx;
               div_rem <= rem_nx;
               bit_cnt <= bit_cnt + BIT_W'(1);
            end
            WRITE: begin
               k <= k + 2'd1;
               if (conv_clear) conv_acc <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cent_we    <= 1'b0;
         cent_idx   <= '0;
         cent_wdata <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         converged  <= 1'b0;
      end else begin
         cent_we <= (state_nx == WRITE);
         done    <= (state_nx == FIN);
         busy    <= (state_nx == LOAD) || (state_nx == DIV_X) ||
                    (state_nx == DIV_Y) || (state_nx == WRITE);
         if ((state == DIV_Y) && last_bit) begin
            cent_idx   <= k;
            cent_wdata <= {qx_r, sat_coord(quo_nx)};
         end
         if ((state == IDLE) && start)
            converged <= 1'b0;
         else if (state_nx == FIN)
            converged <= conv_acc & ~conv_clear;
      end
   end

endmodule

// File: tb/tb_kmeans_update_ctrl.sv
// Testbench for kmeans_update_ctrl: directed and randomized passes checked against
// an arithmetic model of the centroid averages, write sequence, latency and convergence.
module tb_kmeans_update_ctrl;

   localparam int ACC_W   = 20;
   localparam int CNT_W   = 12;
   localparam int COORD_W = 8;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 start = 1'b0;
   logic [1:0]           acc_sel, cent_idx;
   logic [ACC_W-1:0]     acc_x, acc_y;
   logic [CNT_W-1:0]     acc_num;
   logic [2*COORD_W-1:0] cent_rd, cent_wdata;
   logic                 cent_we, busy, done, converged;

   int checks = 0;
   int failures = 0;

   int          ax_arr[4], ay_arr[4], num_arr[4];
   logic [15:0] cent_init[4];
   logic [15:0] cent_arr[4];
   logic        load_cent = 1'b0;

   int          wr_idx_q[$];
   logic [15:0] wr_data_q[$];
   int          exp_idx_q[$];
   logic [15:0] exp_data_q[$];
   int          done_cnt = 0;
   int          consec = 0;
   logic        prev_we = 1'b0;
   int          exp_lat;
   logic        exp_conv;
   int          obs_lat;
   bit          obs_done;

   kmeans_update_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .acc_sel(acc_sel),
      .acc_x(acc_x), .acc_y(acc_y), .acc_num(acc_num), .cent_rd(cent_rd),
      .cent_we(cent_we), .cent_idx(cent_idx), .cent_wdata(cent_wdata),
      .busy(busy), .done(done), .converged(converged)
   );

   always #5 clk = ~clk;

   assign acc_x   = ACC_W'(ax_arr[acc_sel]);
   assign acc_y   = ACC_W'(ay_arr[acc_sel]);
   assign acc_num = CNT_W'(num_arr[acc_sel]);
   assign cent_rd = cent_arr[acc_sel];

   // Centroid register file owned by the surrounding engine.
   always @(posedge clk) begin
      if (load_cent) begin
         for (int i = 0; i < 4; i++) cent_arr[i] <= cent_init[i];
      end else if (cent_we) begin
         cent_arr[cent_idx] <= cent_wdata;
      end
   end

   always @(negedge clk) begin
      if (cent_we) begin
         wr_idx_q.push_back(int'(cent_idx));
         wr_data_q.push_back(cent_wdata);
         if (prev_we) consec <= consec + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
      prev_we <= cent_we;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] model_cent(input int ax, input int ay, input int num);
      int qx, qy;
      qx = ax / num;
      qy = ay / num;
      if (qx > 255) qx = 255;
      if (qy > 255) qy = 255;
      return {8'(qx), 8'(qy)};
   endfunction

   task automatic build_model();
      int n;
      logic [15:0] c;
      n = 0;
      exp_idx_q.delete();
      exp_data_q.delete();
      exp_conv = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (num_arr[k] != 0) begin
            c = model_cent(ax_arr[k], ay_arr[k], num_arr[k]);
            exp_idx_q.push_back(k);
            exp_data_q.push_back(c);
            n++;
            if (c != cent_init[k]) exp_conv = 1'b0;
         end
      end
      exp_lat = 42 * n + (4 - n) + 1;
   endtask

   task automatic set_cluster(input int k, input int ax, input int ay, input int num,
                              input logic [15:0] c);
      ax_arr[k]    = ax;
      ay_arr[k]    = ay;
      num_arr[k]   = num;
      cent_init[k] = c;
   endtask

   task automatic load_centroids();
      @(negedge clk);
      load_cent = 1'b1;
      @(negedge clk);
      load_cent = 1'b0;
   endtask

   // Cycle 1 is the LOAD cycle right after start is sampled.
   task automatic apply_stimulus(input int retrig, input int reset_at);
      obs_done = 1'b0;
      obs_lat  = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", busy, 1);
      for (int i = 1; i <= 400 && !obs_done; i++) begin
         if (i == reset_at) begin
            rst_n = 1'b0;
            #1;
            check("rst_busy", busy, 0);
            check("rst_cent_we", cent_we, 0);
            check("rst_done", done, 0);
            check("rst_wdata", cent_wdata, 0);
            check("rst_acc_sel", acc_sel, 0);
            return;
         end
         start = (i == retrig) || (done && retrig > 0);
         if (done) begin
            obs_done = 1'b1;
            obs_lat  = i;
            check("busy_in_fin", busy, 0);
            check("conv_at_done", converged, exp_conv);
         end else begin
            @(negedge clk);
         end
      end
      if (!obs_done) check("done_timeout", 0, 1);
      @(negedge clk);
      start = 1'b0;
      check("busy_after_done", busy, 0);
      repeat (8) @(negedge clk);
   endtask

   task automatic check_output(input string name, input int wbase, input int dbase,
                               input int cbase);
      int nw;
      nw = wr_idx_q.size() - wbase;
      check({name, "_latency"}, obs_lat, exp_lat);
      check({name, "_conv_held"}, converged, exp_conv);
      check({name, "_write_count"}, nw, exp_idx_q.size());
      for (int i = 0; i < nw && i < exp_idx_q.size(); i++) begin
         check({name, "_wr_idx"}, wr_idx_q[wbase + i], exp_idx_q[i]);
         check({name, "_wr_data"}, wr_data_q[wbase + i], exp_data_q[i]);
      end
      check({name, "_done_pulses"}, done_cnt - dbase, 1);
      check({name, "_back_to_back_we"}, consec - cbase, 0);
   endtask

   task automatic run_pass(input string name, input int retrig);
      int wb, db, cb;
      load_centroids();
      build_model();
      wb = wr_idx_q.size();
      db = done_cnt;
      cb = consec;
      apply_stimulus(retrig, 0);
      check_output(name, wb, db, cb);
   endtask

   initial begin
      int wb, db, q, num;
      for (int k = 0; k < 4; k++) set_cluster(k, 0, 0, 0, 16'h0000);
      repeat (3) @(negedge clk);
      check("reset_acc_sel", acc_sel, 0);
      check("reset_cent_we", cent_we, 0);
      check("reset_cent_idx", cent_idx, 0);
      check("reset_cent_wdata", cent_wdata, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_converged", converged, 0);
      rst_n = 1'b1;

      for (int k = 0; k < 4; k++) set_cluster(k, 1000, 1005, 10, 16'h6464);
      run_pass("all_full", 0);

      set_cluster(2, 1000, 1005, 0, 16'hABCD);
      run_pass("skip_c2", 0);
      check("skip_c2_untouched", cent_arr[2], 16'hABCD);

      for (int k = 0; k < 4; k++) set_cluster(k, 1000, 1005, 10, 16'h6464);
      set_cluster(1, 255, 7, 2, 16'h0000);
      run_pass("c1_change", 0);

      set_cluster(0, 20'hFFFFF, 5, 1, 16'h1234);
      set_cluster(1, 4095 * 255, 0, 4095, 16'hFF00);
      set_cluster(2, 77, 88, 0, 16'h0000);
      set_cluster(3, 5, 9, 0, 16'h0000);
      run_pass("saturate", 0);

      for (int k = 0; k < 4; k++) set_cluster(k, 1000, 1005, 10, 16'h6464);
      run_pass("retrigger", 50);

      load_centroids();
      build_model();
      wb = wr_idx_q.size();
      db = done_cnt;
      apply_stimulus(0, 70);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("midrst_writes", wr_idx_q.size() - wb, 1);
      if (wr_idx_q.size() > wb) check("midrst_wr_idx", wr_idx_q[wb], 0);
      check("midrst_no_done", done_cnt - db, 0);
      check("midrst_converged", converged, 0);
      check("midrst_busy_idle", busy, 0);
      run_pass("after_reset", 0);

      for (int p = 0; p < 4; p++) begin
         for (int k = 0; k < 4; k++) begin
            num = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 4095));
            ax_arr[k] = 0;
            ay_arr[k] = 0;
            if (num != 0) begin
               q = int'($urandom_range(0, 300));
               ax_arr[k] = q * num + int'($urandom_range(0, num - 1));
               q = int'($urandom_range(0, 300));
               ay_arr[k] = q * num + int'($urandom_range(0, num - 1));
               if (ax_arr[k] > 20'hFFFFF) ax_arr[k] = 20'hFFFFF;
               if (ay_arr[k] > 20'hFFFFF) ay_arr[k] = 20'hFFFFF;
            end
            num_arr[k] = num;
            if (num != 0 && $urandom_range(0, 1) == 1)
               cent_init[k] = model_cent(ax_arr[k], ay_arr[k], num);
            else
               cent_init[k] = 16'($urandom);
         end
         run_pass("random", 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
